// File: rtl/cgra_kernel_loader.sv
// rtl/cgra_kernel_loader.sv - kernel launch sequencer: kernel word decode, column allocation, instruction streaming
module cgra_kernel_loader #(
    parameter int N_COL          = 4,
    parameter int KER_CONF_N_REG = 16,
    parameter int IMEM_N_LINES   = 128,
    parameter int RCS_NUM_CREG   = 32,
    parameter int KID_W          = $clog2(KER_CONF_N_REG),
    parameter int IA_W           = $clog2(IMEM_N_LINES),
    parameter int CA_W           = $clog2(RCS_NUM_CREG),
    parameter int KMEM_WIDTH     = N_COL + IA_W + CA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [KID_W-1:0]      ker_id_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  kmem_req_o,
    output logic [KID_W-1:0]      kmem_add_o,
    input  logic [KMEM_WIDTH-1:0] kmem_rdata_i,
    input  logic [N_COL-1:0]      col_free_i,
    output logic [N_COL-1:0]      col_alloc_o,
    output logic                  imem_req_o,
    output logic [IA_W-1:0]       imem_add_o,
    output logic                  cfg_we_o,
    output logic [CA_W-1:0]       cfg_add_o,
    input  logic                  release_i
);

    // Range check needs one extra bit so start + count cannot silently wrap.
    localparam int AW = IA_W + 1;
    // Candidate windows are built double width so a window sliding off the top is detectable.
    localparam int WW = 2 * N_COL;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KREQ,
        ST_DECODE,
        ST_ALLOC,
        ST_LOAD,
        ST_DRAIN,
        ST_RUN,
        ST_ERR
    } state_t;

    state_t state_q, state_d;

    logic [KID_W-1:0] ker_id_q;
    logic [CA_W-1:0]  n_instr_q;
    logic [IA_W-1:0]  imem_start_q;
    logic [N_COL-1:0] n_col_q;
    logic [CA_W-1:0]  idx_q;
    logic [IA_W-1:0]  imem_add_q;
    logic [N_COL-1:0] col_alloc_q;
    logic             cfg_we_q;
    logic [CA_W-1:0]  cfg_add_q;
    logic             done_q;

    // Fields of the kernel word as it arrives, checked before being registered.
    logic [CA_W-1:0]  dec_n_instr;
    logic [IA_W-1:0]  dec_start;
    logic [N_COL-1:0] dec_n_col;
    logic             dec_onehot;
    logic [AW-1:0]    dec_end;
    logic             dec_bad;

    assign dec_n_instr = kmem_rdata_i[CA_W-1:0];
    assign dec_start   = kmem_rdata_i[CA_W+IA_W-1:CA_W];
    assign dec_n_col   = kmem_rdata_i[KMEM_WIDTH-1:CA_W+IA_W];
    assign dec_onehot  = (dec_n_col != '0) && ((dec_n_col & (dec_n_col - N_COL'(1))) == '0);
    assign dec_end     = AW'(dec_start) + AW'(dec_n_instr) + AW'(1);
    assign dec_bad     = (ker_id_q == '0) || !dec_onehot || (dec_end > AW'(IMEM_N_LINES));

    // One-hot bit k turns into a mask of k+1 low ones (bit N_COL-1 wraps to all ones).
    logic [N_COL-1:0] need_mask;
    assign need_mask = (n_col_q << 1) - N_COL'(1);

    logic             load_last;
    assign load_last = (idx_q == n_instr_q);

    logic             win_found;
    logic [N_COL-1:0] win_mask;
    logic [WW-1:0]    cand;

    // Lowest-index window of contiguous free columns large enough for the kernel.
    always_comb begin
        win_found = 1'b0;
        win_mask  = '0;
        cand      = '0;
        for (int s = 0; s < N_COL; s++) begin
            cand = WW'(need_mask) << s;
            if (!win_found && (cand[WW-1:N_COL] == '0) &&
                ((cand[N_COL-1:0] & ~col_free_i) == '0)) begin
                win_found = 1'b1;
                win_mask  = cand[N_COL-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and state-decoded strobes.
    always_comb begin
        state_d    = state_q;
        busy_o     = 1'b1;
        err_o      = 1'b0;
        kmem_req_o = 1'b0;
        kmem_add_o = '0;
        imem_req_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = ST_KREQ;
            end
            ST_KREQ: begin
                kmem_req_o = 1'b1;
                kmem_add_o = ker_id_q;
                state_d    = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = dec_bad ? ST_ERR : ST_ALLOC;
            end
            ST_ALLOC: begin
                if (win_found) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                imem_req_o = 1'b1;
                if (load_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                busy_o = 1'b0;
                if (release_i) state_d = ST_IDLE;
            end
            ST_ERR: begin
                err_o   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Launch datapath: captured ID and fields, line/index counters, delayed config write, allocation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ker_id_q     <= '0;
            n_instr_q    <= '0;
            imem_start_q <= '0;
            n_col_q      <= '0;
            idx_q        <= '0;
            imem_add_q   <= '0;
            col_alloc_q  <= '0;
            cfg_we_q     <= 1'b0;
            cfg_add_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start_i) begin
                ker_id_q <= ker_id_i;
            end
            if (state_q == ST_DECODE) begin
                n_instr_q    <= dec_n_instr;
                imem_start_q <= dec_start;
                n_col_q      <= dec_n_col;
            end
            if (state_q == ST_ALLOC && win_found) begin
                col_alloc_q <= win_mask;
                idx_q       <= '0;
                imem_add_q  <= imem_start_q;
            end
            if (state_q == ST_LOAD && !load_last) begin
                idx_q      <= idx_q + CA_W'(1);
                imem_add_q <= imem_add_q + IA_W'(1);
            end
            if (state_q == ST_RUN && release_i) begin
                col_alloc_q <= '0;
            end
            cfg_we_q <= (state_q == ST_LOAD);
            if (state_q == ST_LOAD) begin
                cfg_add_q <= idx_q;
            end
            done_q <= (state_q == ST_DRAIN);
        end
    end

    assign imem_add_o  = imem_add_q;
    assign cfg_we_o    = cfg_we_q;
    assign cfg_add_o   = cfg_add_q;
    assign col_alloc_o = col_alloc_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_cgra_kernel_loader.sv
// tb/tb_cgra_kernel_loader.sv - directed bench for cgra_kernel_loader
module tb_cgra_kernel_loader;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start;
    logic [3:0]  ker_id;
    logic        busy;
    logic        done;
    logic        err;
    logic        kmem_req;
    logic [3:0]  kmem_add;
    logic [15:0] kmem_rdata = '0;
    logic [3:0]  col_free;
    logic [3:0]  col_alloc;
    logic        imem_req;
    logic [6:0]  imem_add;
    logic        cfg_we;
    logic [4:0]  cfg_add;
    logic        rel;

    logic [15:0] kmem [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cgra_kernel_loader dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start),
        .ker_id_i     (ker_id),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .kmem_req_o   (kmem_req),
        .kmem_add_o   (kmem_add),
        .kmem_rdata_i (kmem_rdata),
        .col_free_i   (col_free),
        .col_alloc_o  (col_alloc),
        .imem_req_o   (imem_req),
        .imem_add_o   (imem_add),
        .cfg_we_o     (cfg_we),
        .cfg_add_o    (cfg_add),
        .release_i    (rel)
    );

    always @(posedge clk) begin
        if (kmem_req) kmem_rdata <= kmem[kmem_add];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " err"}, err, 0);
        check({tag, " kmem_req"}, kmem_req, 0);
        check({tag, " kmem_add"}, kmem_add, 0);
        check({tag, " col_alloc"}, col_alloc, 0);
        check({tag, " imem_req"}, imem_req, 0);
        check({tag, " imem_add"}, imem_add, 0);
        check({tag, " cfg_we"}, cfg_we, 0);
        check({tag, " cfg_add"}, cfg_add, 0);
    endtask

    task automatic launch(input int id, input logic [3:0] exp_alloc, input int st, input int n,
                          input logic [3:0] free0, input logic [3:0] free1, input int stall,
                          input bit poke);
        int b;
        b = 4 + stall;
        col_free = free0;
        @(negedge clk);
        ker_id = 4'(id);
        start  = 1'b1;
        for (int c = 1; c <= b + n + 3; c++) begin
            @(negedge clk);
            check($sformatf("id%0d kmem_req c%0d", id, c), kmem_req, (c == 1));
            if (c == 1) check($sformatf("id%0d kmem_add", id), kmem_add, id);
            check($sformatf("id%0d imem_req c%0d", id, c), imem_req, (c >= b && c <= b + n));
            if (c >= b && c <= b + n)
                check($sformatf("id%0d imem_add c%0d", id, c), imem_add, st + c - b);
            if (c == b + n + 1)
                check($sformatf("id%0d imem_add hold", id), imem_add, st + n);
            check($sformatf("id%0d cfg_we c%0d", id, c), cfg_we, (c >= b + 1 && c <= b + 1 + n));
            if (c >= b + 1 && c <= b + 1 + n)
                check($sformatf("id%0d cfg_add c%0d", id, c), cfg_add, c - b - 1);
            if (c == b + n + 2)
                check($sformatf("id%0d cfg_add hold", id), cfg_add, n);
            check($sformatf("id%0d done c%0d", id, c), done, (c == b + n + 2));
            check($sformatf("id%0d err c%0d", id, c), err, 0);
            check($sformatf("id%0d col_alloc c%0d", id, c), col_alloc, (c >= b) ? exp_alloc : 4'b0);
            check($sformatf("id%0d busy c%0d", id, c), busy, (c < b + n + 2));
            if (c == 1) start = 1'b0;
            if (c == 3 + stall) col_free = free1;
            if (poke && c == b + 1) begin
                start  = 1'b1;
                ker_id = 4'd5;
            end
            if (poke && c == b + 2) start = 1'b0;
        end
        rel = 1'b1;
        if (poke) begin
            start  = 1'b1;
            ker_id = 4'd2;
        end
        @(negedge clk);
        rel   = 1'b0;
        start = 1'b0;
        check($sformatf("id%0d released col_alloc", id), col_alloc, 0);
        check($sformatf("id%0d released busy", id), busy, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("id%0d idle kmem_req k%0d", id, k), kmem_req, 0);
            check($sformatf("id%0d idle busy k%0d", id, k), busy, 0);
        end
    endtask

    task automatic launch_err(input int id);
        col_free = 4'b1111;
        @(negedge clk);
        ker_id = 4'(id);
        start  = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("err%0d kmem_req c%0d", id, c), kmem_req, (c == 1));
            check($sformatf("err%0d err c%0d", id, c), err, (c == 3));
            check($sformatf("err%0d imem_req c%0d", id, c), imem_req, 0);
            check($sformatf("err%0d cfg_we c%0d", id, c), cfg_we, 0);
            check($sformatf("err%0d col_alloc c%0d", id, c), col_alloc, 0);
            check($sformatf("err%0d done c%0d", id, c), done, 0);
            check($sformatf("err%0d busy c%0d", id, c), busy, (c <= 3));
            if (c == 1) start = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) kmem[i] = '0;
        kmem[0] = {4'b0010, 7'd10, 5'd3};
        kmem[2] = {4'b0010, 7'd10, 5'd3};
        kmem[3] = {4'b0010, 7'd0, 5'd1};
        kmem[4] = {4'b0101, 7'd0, 5'd0};
        kmem[5] = {4'b0001, 7'd120, 5'd15};
        kmem[6] = {4'b0001, 7'd96, 5'd31};
        kmem[7] = {4'b0001, 7'd20, 5'd7};

        rst_ni   = 1'b0;
        start    = 1'b0;
        ker_id   = '0;
        col_free = '0;
        rel      = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_ni = 1'b1;
        @(negedge clk);

        launch(2, 4'b0011, 10, 3, 4'b1111, 4'b1111, 0, 1'b0);
        launch(3, 4'b0110, 0, 1, 4'b1010, 4'b1110, 3, 1'b0);
        launch_err(0);
        launch_err(4);
        launch_err(5);
        launch(6, 4'b0001, 96, 31, 4'b1111, 4'b1111, 0, 1'b0);

        col_free = 4'b1111;
        @(negedge clk);
        ker_id = 4'd7;
        start  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 4) check("abort first imem_add", imem_add, 20);
            if (c == 6) begin
                check("abort third imem_req", imem_req, 1);
                check("abort third imem_add", imem_add, 22);
                check("abort col_alloc", col_alloc, 4'b0001);
            end
        end
        rst_ni = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        rst_ni = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("post-abort done k%0d", k), done, 0);
            check($sformatf("post-abort busy k%0d", k), busy, 0);
            check($sformatf("post-abort cfg_we k%0d", k), cfg_we, 0);
        end
        launch(2, 4'b0011, 10, 3, 4'b1111, 4'b1111, 0, 1'b0);

        launch(2, 4'b0011, 10, 3, 4'b1111, 4'b1111, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
